frog_lane_engine: RTL
=====================

# frog_lane_engine

Parametrised game-logic core for the VGA Frogger design: LANES rows × COLS columns of scrolling obstacle bit-maps, one player token, collision detection, lives and a play/hit/win/over state machine. Replaces the fixed 8×8 hard-coded lane tables. Buttons are synchronised and edge-detected, so each press moves exactly one cell. Lanes have per-lane direction and speed. Outputs feed the VGA pixel writer, which decodes `lanes` and the frog position per cell.

## Interface
Parameters:
- LANES, 8, number of rows. Row 0 is the goal, row LANES-1 is the start. Minimum 3.
- COLS, 8, columns per row. Bit COLS-1 is the leftmost column. Minimum 2.
- TICK_DIV, 100000000, clk cycles per game tick. Minimum 2.
- LIVES, 3, lives at start and after restart. Minimum 1.
- HIT_TICKS, 2, ticks the frog stays frozen after a hit.
- LANE_INIT, LANES*COLS bits, initial bit-map; row r = bits [r*COLS +: COLS].
- LANE_DIR, LANES bits: 1 = rotate right (toward bit 0), 0 = rotate left.
- LANE_SLOW, LANES bits: 1 = shift on every second tick only.
- SAFE_MASK, LANES bits: 1 = row never collides. Rows 0 and LANES-1 are always safe.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- up_n, down_n, left_n, right_n  in  1 each  raw active-low buttons, asynchronous to clk
- lanes  out  LANES*COLS  current obstacle bit-map
- frog_row  out  $clog2(LANES)  frog row
- frog_col  out  COLS  one-hot frog column
- lives  out  $clog2(LIVES+1)  remaining lives
- state  out  2  0=PLAY, 1=HIT, 2=WIN, 3=OVER
- tick  out  1  one-cycle game-tick pulse
- dead_p  out  1  one-cycle pulse on each hit
- win_p  out  1  one-cycle pulse on reaching row 0

## Operation
- Reset values:
  - lanes = LANE_INIT
  - frog_row = LANES-1
  - frog_col = bit COLS/2 set
  - lives = LIVES
  - state = PLAY
  - tick, dead_p, win_p = 0
  - divider, slow-phase bit and sync flops are cleared, with sync flops set to the released level (1).
- Tick generation: the divider counts 0..TICK_DIV-1. `tick`=1 in the cycle the divider equals TICK_DIV-1, then the divider wraps to 0. The slow-phase bit toggles on each tick.
- Lane shift: on tick, row r rotates by one position per LANE_DIR[r]. Slow rows rotate only on ticks where the slow-phase bit is 1 before toggling. Lanes scroll in every state, including OVER.
- Input path: each button goes through a 2-flop synchroniser. A press is a 1→0 transition on the synchronised value. Holding a button produces no further moves.
- Moves are applied in PLAY only:
  - up decrements frog_row; down increments frog_row, saturating at LANES-1.
  - left shifts frog_col toward the MSB; right shifts toward the LSB. Both saturate at the edge with no change.
  - up and down pressed in the same cycle cancel; left and right likewise. A vertical and a horizontal press in the same cycle both apply.
- Collision: in PLAY, when the row is not safe and (lanes row frog_row & frog_col) != 0:
  - next cycle state=HIT, dead_p=1, lives decrements.
  - If lives was 1, state goes to OVER instead and lives=0.
- HIT: the frog is frozen and presses are ignored. After HIT_TICKS ticks, the frog returns to the start position and state=PLAY.
- Win: when frog_row becomes 0 in PLAY, next cycle state=WIN and win_p=1. Any press then returns the frog to start and state=PLAY, with lives kept.
- OVER: any press restores lives=LIVES, frog to start, state=PLAY. Lanes are not reloaded.

## Timing
- Button to move: press edge at the pin appears on frog_row/frog_col 3 cycles later (2 sync flops + 1 update register).
- Collision and win are evaluated on registered frog and lane values and take effect the following cycle. A move and a lane shift in the same cycle both apply, and the collision check sees the combined result one cycle later.
- Simultaneous collision and win cannot occur, since row 0 is safe.
- Reset asserted mid-tick or mid-HIT returns all state to reset values immediately. After release, the first tick follows TICK_DIV cycles later.
- dead_p and win_p never assert in the same cycle. Each is exactly one cycle wide.

## Test plan
All scenarios use LANES=4, COLS=4, TICK_DIV=4, LIVES=2, HIT_TICKS=1, LANE_INIT row1=4'b1000, rows 0/2/3=0, LANE_DIR=0, LANE_SLOW=0, SAFE_MASK=0.
- Reset release, no input → tick pulses on cycles 3, 7, 11; row 1 sequence is 1000, 0001, 0010, 0100.
- Hold up_n low for 20 cycles → frog_row goes 3→2 exactly once, 3 cycles after the edge.
- Press left three times from col 0100 → frog_col becomes 1000 then stays 1000.
- Move the frog into row 1 at a column aligned with the obstacle → dead_p one cycle, lives 2→1, state HIT. After one tick, frog back at row 3, col 0100, state PLAY.
- Second collision → lives 0, state OVER. Any press → lives 2, state PLAY.
- Time the moves so row 1 is clear, then reach row 0 → win_p one cycle, state WIN. Press → frog at start, lives unchanged.

Source files
------------

// File: rtl/frog_lane_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// frog_lane_engine : Frogger game core (scrolling lanes, frog, lives, FSM)
// Revision: 1.0
// ============================================================================
module frog_lane_engine #(
   parameter int LANES     = 8,
   parameter int COLS      = 8,
   parameter int TICK_DIV  = 100000000,
   parameter int LIVES     = 3,
   parameter int HIT_TICKS = 2,
   parameter logic [LANES*COLS-1:0] LANE_INIT = 64'h003C_8166_00C3_1800,
   parameter logic [LANES-1:0]      LANE_DIR  = 8'b0101_0100,
   parameter logic [LANES-1:0]      LANE_SLOW = 8'b0010_0100,
   parameter logic [LANES-1:0]      SAFE_MASK = 8'b0000_1000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       up_n,
   input  logic                       down_n,
   input  logic                       left_n,
   input  logic                       right_n,
   output logic [LANES*COLS-1:0]      lanes,
   output logic [$clog2(LANES)-1:0]   frog_row,
   output logic [COLS-1:0]            frog_col,
   output logic [$clog2(LIVES+1)-1:0] lives,
   output logic [1:0]                 state,
   output logic                       tick,
   output logic                       dead_p,
   output logic                       win_p
);
   localparam int ROW_W  = $clog2(LANES);
   localparam int LIFE_W = $clog2(LIVES+1);
   localparam int DIV_W  = $clog2(TICK_DIV);
   localparam int HIT_W  = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
   localparam logic [ROW_W-1:0]  START_ROW = ROW_W'(LANES-1);
   localparam logic [COLS-1:0]   START_COL = COLS'(1) << (COLS/2);
   localparam logic [LANES-1:0]  SAFE_ROWS = SAFE_MASK | {1'b1, {(LANES-2){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_PLAY = 2'd0,
      ST_HIT  = 2'd1,
      ST_WIN  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   state_t                  r_state;
   logic [DIV_W-1:0]        r_div;
   logic                    r_slow;
   logic [3:0]              r_sync1, r_sync2, r_sync3;
   logic [LANES*COLS-1:0]   r_lanes;
   logic [ROW_W-1:0]        r_frog_row;
   logic [COLS-1:0]         r_frog_col;
   logic [LIFE_W-1:0]       r_lives;
   logic [HIT_W-1:0]        r_hit_cnt;
   logic                    r_dead_p, r_win_p;

   logic                    w_tick;
   logic [3:0]              w_press;
   logic                    w_any_press, w_hit;
   logic [LANES*COLS-1:0]   w_lanes_next;
   logic [COLS-1:0]         w_rows [LANES];

   assign w_tick      = (r_div == DIV_W'(TICK_DIV-1));
   // Bit order: [3]=up, [2]=down, [1]=left, [0]=right; press = 1->0 after sync
   assign w_press     = r_sync3 & ~r_sync2;
   assign w_any_press = |w_press;
   assign w_hit       = ~SAFE_ROWS[r_frog_row] & (|(w_rows[r_frog_row] & r_frog_col));

   for (genvar r = 0; r < LANES; r++) begin : g_lane
      logic [COLS-1:0] w_row;
      logic            w_shift;
      assign w_row   = r_lanes[r*COLS +: COLS];
      assign w_rows[r] = w_row;
      assign w_shift = w_tick & (~LANE_SLOW[r] | r_slow);
      assign w_lanes_next[r*COLS +: COLS] = !w_shift    ? w_row :
                                            LANE_DIR[r] ? {w_row[0], w_row[COLS-1:1]} :
                                                          {w_row[COLS-2:0], w_row[COLS-1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div   <= '0;
         r_slow  <= 1'b0;
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_sync3 <= '1;
         r_lanes <= LANE_INIT;
      end else begin
         r_div   <= w_tick ? '0 : r_div + DIV_W'(1);
         r_slow  <= r_slow ^ w_tick;
         r_sync1 <= {up_n, down_n, left_n, right_n};
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_lanes <= w_lanes_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_PLAY;
         r_frog_row <= START_ROW;
         r_frog_col <= START_COL;
         r_lives    <= LIFE_W'(LIVES);
         r_hit_cnt  <= '0;
         r_dead_p   <= 1'b0;
         r_win_p    <= 1'b0;
      end else begin
         r_dead_p <= 1'b0;
         r_win_p  <= 1'b0;
         case (r_state)
            ST_PLAY: begin
               // Collision and win outrank any move arriving in the same cycle
               if (w_hit) begin
                  r_dead_p  <= 1'b1;
                  r_hit_cnt <= '0;
                  if (r_lives == LIFE_W'(1)) begin
                     r_state <= ST_OVER;
                     r_lives <= '0;
                  end else begin
                     r_state <= ST_HIT;
                     r_lives <= r_lives - LIFE_W'(1);
                  end
               end else if (r_frog_row == '0) begin
                  r_state <= ST_WIN;
                  r_win_p <= 1'b1;
               end else begin
                  if (w_press[3] && !w_press[2] && r_frog_row != '0)
                     r_frog_row <= r_frog_row - ROW_W'(1);
                  else if (w_press[2] && !w_press[3] && r_frog_row != START_ROW)
                     r_frog_row <= r_frog_row + ROW_W'(1);
                  if (w_press[1] && !w_press[0] && !r_frog_col[COLS-1])
                     r_frog_col <= r_frog_col << 1;
                  else if (w_press[0] && !w_press[1] && !r_frog_col[0])
                     r_frog_col <= r_frog_col >> 1;
               end
            end
            ST_HIT: begin
               if (w_tick) begin
                  if (r_hit_cnt == HIT_W'(HIT_TICKS-1)) begin
                     r_state    <= ST_PLAY;
                     r_frog_row <= START_ROW;
                     r_frog_col <= START_COL;
                  end else begin
                     r_hit_cnt <= r_hit_cnt + HIT_W'(1);
                  end
               end
            end
            ST_WIN: begin
               if (w_any_press) begin
                  r_state    <= ST_PLAY;
                  r_frog_row <= START_ROW;
                  r_frog_col <= START_COL;
               end
            end
            default: begin
               if (w_any_press) begin
                  r_state    <= ST_PLAY;
                  r_frog_row <= START_ROW;
                  r_frog_col <= START_COL;
                  r_lives    <= LIFE_W'(LIVES);
               end
            end
         endcase
      end
   end

   assign lanes    = r_lanes;
   assign frog_row = r_frog_row;
   assign frog_col = r_frog_col;
   assign lives    = r_lives;
   assign state    = r_state;
   assign tick     = w_tick;
   assign dead_p   = r_dead_p;
   assign win_p    = r_win_p;
endmodule
`default_nettype wire
